// File: rtl/oh_pkg.sv
// Shared definitions for the operand-handler arbiter.
//   - Operand-select (S) codes understood by the shared handler.
//   - Response-register state encoding.
//   - Helper to spot the reserved select code.
package oh_pkg;

  localparam logic [2:0] PASS   = 3'b000;
  localparam logic [2:0] SEXT11 = 3'b001;
  localparam logic [2:0] SEXT14 = 3'b010;
  localparam logic [2:0] LUI    = 3'b011;
  localparam logic [2:0] SHR    = 3'b100;
  localparam logic [2:0] SHRA   = 3'b101;
  localparam logic [2:0] SHL    = 3'b110;
  localparam logic [2:0] RSVD   = 3'b111;

  // EMPTY: response register free; FULL: response register holds a result.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic logic is_rsvd(input logic [2:0] s);
    return s == RSVD;
  endfunction

endpackage

// File: rtl/oh_arbiter_if.sv
// Bus bundle for oh_arbiter.
//   req0_* / req1_* : requester valid/ready handshake and payload
//   oh_*            : drive to / result from the shared operand handler
//   rsp_*           : one-deep response with valid/ready handshake
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters, handler, consumer)
interface oh_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 21,
  parameter int SEL_W  = 3,
  parameter int TAG_W  = 4
) ();

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_rb;
  logic [IMM_W-1:0]  req0_i;
  logic [SEL_W-1:0]  req0_s;
  logic [TAG_W-1:0]  req0_tag;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_rb;
  logic [IMM_W-1:0]  req1_i;
  logic [SEL_W-1:0]  req1_s;
  logic [TAG_W-1:0]  req1_tag;

  logic [DATA_W-1:0] oh_rb;
  logic [IMM_W-1:0]  oh_i;
  logic [SEL_W-1:0]  oh_s;
  logic [DATA_W-1:0] oh_n;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_rb, req0_i, req0_s, req0_tag,
    output req0_ready,
    input  req1_valid, req1_rb, req1_i, req1_s, req1_tag,
    output req1_ready,
    output oh_rb, oh_i, oh_s,
    input  oh_n,
    output rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_rb, req0_i, req0_s, req0_tag,
    input  req0_ready,
    output req1_valid, req1_rb, req1_i, req1_s, req1_tag,
    input  req1_ready,
    input  oh_rb, oh_i, oh_s,
    output oh_n,
    input  rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/oh_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   valid0/valid1 : request valids
//   can_accept    : downstream register can take a result this cycle
//   last_grant    : requester granted most recently
//   grant_valid   : a grant is issued this cycle
//   grant         : granted requester index (meaningful with grant_valid)
//   ready0/ready1 : per-requester accept strobes
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic can_accept,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant,
  output logic ready0,
  output logic ready1
);

  // NOTE: every output of a combinational block gets a default before any
  // branch, otherwise an unassigned path infers a latch.
  always_comb begin
    grant = 1'b0;
    if (valid0 && valid1) begin
      grant = ~last_grant;          // contention: favour the one not served last
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

  assign grant_valid = can_accept & (valid0 | valid1);
  assign ready0      = grant_valid & ~grant;
  assign ready1      = grant_valid &  grant;

endmodule

// File: rtl/oh_arbiter.sv
// Shares one operand-handler datapath between two requesters.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : oh_arbiter_if slave modport carrying both request
//                channels, the handler drive/result and the response
// The granted request is steered combinationally onto oh_rb/oh_i/oh_s and
// the handler result oh_n is captured into a one-deep response register on
// the accept edge. A response drained every cycle allows one accept per cycle.
module oh_arbiter
  import oh_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 21,
  parameter int SEL_W  = 3,
  parameter int TAG_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  oh_arbiter_if.slave  bus
);

  state_e            state;
  state_e            state_nxt;
  logic              last_grant;

  logic              can_accept;
  logic              grant_valid;
  logic              grant;
  logic              ready0;
  logic              ready1;

  logic [DATA_W-1:0] sel_rb;
  logic [IMM_W-1:0]  sel_i;
  logic [SEL_W-1:0]  sel_s;
  logic [TAG_W-1:0]  sel_tag;

  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_id_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic              rsp_err_q;

  // A draining consumer frees the register in the same cycle, which is what
  // allows back-to-back accepts.
  assign can_accept = (state == EMPTY) | bus.rsp_ready;

  rr_arb2 u_rr_arb2 (
    .valid0      (bus.req0_valid),
    .valid1      (bus.req1_valid),
    .can_accept  (can_accept),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant),
    .ready0      (ready0),
    .ready1      (ready1)
  );

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  // Idle drive selects the reserved code with zero operands so the handler
  // output stays quiet when nothing is granted.
  always_comb begin
    sel_rb  = '0;
    sel_i   = '0;
    sel_s   = SEL_W'(RSVD);
    sel_tag = '0;
    if (grant_valid) begin
      if (grant) begin
        sel_rb  = bus.req1_rb;
        sel_i   = bus.req1_i;
        sel_s   = bus.req1_s;
        sel_tag = bus.req1_tag;
      end else begin
        sel_rb  = bus.req0_rb;
        sel_i   = bus.req0_i;
        sel_s   = bus.req0_s;
        sel_tag = bus.req0_tag;
      end
    end
  end

  assign bus.oh_rb = sel_rb;
  assign bus.oh_i  = sel_i;
  assign bus.oh_s  = sel_s;

  always_comb begin
    state_nxt = state;
    if (grant_valid) begin
      state_nxt = FULL;
    end else if (bus.rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the response payload is reset as well, so a freshly reset block
  // presents all-zero rsp_* rather than stale or X data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;   // req0 wins the first contention after reset
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_valid) begin
        rsp_data_q <= bus.oh_n;
        rsp_id_q   <= grant;
        rsp_tag_q  <= sel_tag;
        rsp_err_q  <= is_rsvd(3'(sel_s));
        last_grant <= grant;
      end
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_oh_arbiter.sv
// Self-checking bench for oh_arbiter: table-driven vectors, hand-written
// backpressure / priority / async-reset sequences and a response scoreboard.
module tb_oh_arbiter;
  import oh_pkg::*;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 21;
  localparam int SEL_W  = 3;
  localparam int TAG_W  = 4;

  logic clk;
  logic rst_n;

  oh_arbiter_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SEL_W(SEL_W), .TAG_W(TAG_W)) bus ();

  oh_arbiter #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SEL_W(SEL_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shared operand handler.
  function automatic logic [31:0] handler(input logic [31:0] rb, input logic [20:0] i,
                                          input logic [2:0] s);
    case (s)
      PASS:    return rb;
      SEXT11:  return {{21{i[10]}}, i[10:0]};
      SEXT14:  return {{18{i[13]}}, i[13:0]};
      LUI:     return {i, 11'b0};
      SHR:     return rb >> i[4:0];
      SHRA:    return 32'($signed(rb) >>> i[4:0]);
      SHL:     return rb << i[4:0];
      default: return 32'h0;
    endcase
  endfunction

  assign bus.oh_n = handler(bus.oh_rb, bus.oh_i, bus.oh_s);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and spec-level model state.
  typedef struct {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];
  logic m_full;
  logic m_last;

  task automatic drive(input logic v0, input logic v1, input logic rr,
                       input logic [31:0] rb0, input logic [20:0] i0, input logic [2:0] s0,
                       input logic [3:0] t0,
                       input logic [31:0] rb1, input logic [20:0] i1, input logic [2:0] s1,
                       input logic [3:0] t1);
    bus.req0_valid = v0; bus.req0_rb = rb0; bus.req0_i = i0; bus.req0_s = s0; bus.req0_tag = t0;
    bus.req1_valid = v1; bus.req1_rb = rb1; bus.req1_i = i1; bus.req1_s = s1; bus.req1_tag = t1;
    bus.rsp_ready  = rr;
  endtask

  task automatic drive_idle(input logic rr);
    drive(1'b0, 1'b0, rr, '0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  // Called mid-cycle (after the negedge): compares DUT against the model and
  // advances the model as if the coming posedge happens.
  task automatic step();
    logic can_acc, gv, g;
    logic [31:0] g_rb;
    logic [20:0] g_i;
    logic [2:0]  g_s;
    logic [3:0]  g_t;
    rsp_t e;
    can_acc = !m_full || bus.rsp_ready;
    gv      = can_acc && (bus.req0_valid || bus.req1_valid);
    g       = (bus.req0_valid && bus.req1_valid) ? !m_last : !bus.req0_valid;
    g_rb    = g ? bus.req1_rb  : bus.req0_rb;
    g_i     = g ? bus.req1_i   : bus.req0_i;
    g_s     = g ? bus.req1_s   : bus.req0_s;
    g_t     = g ? bus.req1_tag : bus.req0_tag;
    check("req0_ready", 64'(bus.req0_ready), 64'(gv && !g));
    check("req1_ready", 64'(bus.req1_ready), 64'(gv && g));
    check("oh_rb", 64'(bus.oh_rb), gv ? 64'(g_rb) : 64'(0));
    check("oh_i",  64'(bus.oh_i),  gv ? 64'(g_i)  : 64'(0));
    check("oh_s",  64'(bus.oh_s),  gv ? 64'(g_s)  : 64'(RSVD));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_full));
    if (m_full && sb_q.size() > 0) begin
      e = sb_q[0];
      check("rsp_id",   64'(bus.rsp_id),   64'(e.id));
      check("rsp_tag",  64'(bus.rsp_tag),  64'(e.tag));
      check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
      check("rsp_err",  64'(bus.rsp_err),  64'(e.err));
      if (bus.rsp_ready) void'(sb_q.pop_front());
    end
    if (gv) begin
      e.id   = g;
      e.tag  = g_t;
      e.data = handler(g_rb, g_i, g_s);
      e.err  = (g_s == RSVD);
      sb_q.push_back(e);
      m_last = g;
    end
    m_full = gv ? 1'b1 : (bus.rsp_ready ? 1'b0 : m_full);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v0, v1, rr;
    logic [31:0] rb0; logic [20:0] i0; logic [2:0] s0; logic [3:0] t0;
    logic [31:0] rb1; logic [20:0] i1; logic [2:0] s1; logic [3:0] t1;
    logic        exp_r0, exp_r1;
    logic        chk_rsp;
    logic [31:0] exp_data;
    logic        exp_id, exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] held_data;
    logic [3:0]  held_tag;

    // v0 v1 rr | req0 rb,i,s,tag | req1 rb,i,s,tag | r0 r1 | chk data id err
    tbl[0] = '{1,0,1, 32'h8431FFEB,21'h104761,PASS,4'h3, 32'h0,21'h0,PASS,4'h0,
               1,0, 0,32'h0,0,0};
    tbl[1] = '{1,1,1, 32'hF0000000,21'h000004,SHR,4'h9, 32'h0,21'h104761,LUI,4'h5,
               0,1, 1,32'h8431FFEB,0,0};
    tbl[2] = '{1,1,1, 32'hF0000000,21'h000004,SHR,4'h9, 32'h0,21'h104761,LUI,4'h5,
               1,0, 1,32'h823B0800,1,0};
    tbl[3] = '{1,1,1, 32'h0,21'h000400,SEXT11,4'h2, 32'h0,21'h104761,LUI,4'h5,
               0,1, 1,32'h0F000000,0,0};
    tbl[4] = '{1,1,1, 32'h80000000,21'h000004,SHRA,4'h7, 32'h0,21'h104761,LUI,4'h5,
               1,0, 1,32'h823B0800,1,0};
    tbl[5] = '{0,1,1, 32'h0,21'h0,PASS,4'h0, 32'hFFFFFFFF,21'h0,RSVD,4'hA,
               0,1, 1,32'hF8000000,0,0};
    tbl[6] = '{0,0,1, 32'h0,21'h0,PASS,4'h0, 32'h0,21'h0,PASS,4'h0,
               0,0, 1,32'h00000000,1,1};
    tbl[7] = '{0,0,1, 32'h0,21'h0,PASS,4'h0, 32'h0,21'h0,PASS,4'h0,
               0,0, 0,32'h0,0,0};

    // Reset state
    rst_n = 1'b0;
    drive_idle(1'b1);
    m_full = 1'b0;
    m_last = 1'b1;
    #1;
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("reset_rsp_data",  64'(bus.rsp_data),  64'(0));
    check("reset_rsp_id",    64'(bus.rsp_id),    64'(0));
    check("reset_rsp_tag",   64'(bus.rsp_tag),   64'(0));
    check("reset_rsp_err",   64'(bus.rsp_err),   64'(0));
    check("reset_oh_s",      64'(bus.oh_s),      64'(RSVD));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].v0, tbl[k].v1, tbl[k].rr,
            tbl[k].rb0, tbl[k].i0, tbl[k].s0, tbl[k].t0,
            tbl[k].rb1, tbl[k].i1, tbl[k].s1, tbl[k].t1);
      @(negedge clk);
      check($sformatf("tbl%0d_req0_ready", k), 64'(bus.req0_ready), 64'(tbl[k].exp_r0));
      check($sformatf("tbl%0d_req1_ready", k), 64'(bus.req1_ready), 64'(tbl[k].exp_r1));
      if (tbl[k].chk_rsp) begin
        check($sformatf("tbl%0d_rsp_data", k), 64'(bus.rsp_data), 64'(tbl[k].exp_data));
        check($sformatf("tbl%0d_rsp_id", k),   64'(bus.rsp_id),   64'(tbl[k].exp_id));
        check($sformatf("tbl%0d_rsp_err", k),  64'(bus.rsp_err),  64'(tbl[k].exp_err));
      end
      step();
      tick();
    end

    // Backpressure: fill, hold 3 cycles, then drain and accept together.
    drive(1, 0, 1, 32'h12345678, 21'h0, PASS, 4'h1, '0, '0, '0, '0);
    @(negedge clk); step(); tick();
    held_data = 32'h12345678;
    held_tag  = 4'h1;
    drive(1, 1, 0, 32'hAAAA5555, 21'h0, PASS, 4'h2, 32'h0000FFFF, 21'h8, SHL, 4'h6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_req0_ready", 64'(bus.req0_ready), 64'(0));
      check("hold_req1_ready", 64'(bus.req1_ready), 64'(0));
      check("hold_rsp_data",   64'(bus.rsp_data),   64'(held_data));
      check("hold_rsp_tag",    64'(bus.rsp_tag),    64'(held_tag));
      step();
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("drain_req1_ready", 64'(bus.req1_ready), 64'(1));
    step(); tick();
    drive_idle(1'b1);
    @(negedge clk);
    check("drain_rsp_data", 64'(bus.rsp_data), 64'(32'h00FFFF00));
    step(); tick();

    // Priority memory: req1 alone, 5 idle cycles, then contention.
    drive(0, 1, 1, '0, '0, '0, '0, 32'h1, 21'h0, PASS, 4'hC);
    @(negedge clk); step(); tick();
    drive_idle(1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); step(); tick();
    end
    drive(1, 1, 1, 32'h2, 21'h0, PASS, 4'hD, 32'h3, 21'h0, PASS, 4'hE);
    @(negedge clk);
    check("prio_mem_req0_ready", 64'(bus.req0_ready), 64'(1));
    step(); tick();
    drive_idle(1'b1);
    @(negedge clk); step(); tick();

    // Async reset while FULL under backpressure.
    drive(0, 1, 1, '0, '0, '0, '0, 32'h77, 21'h0, PASS, 4'h4);
    @(negedge clk); step(); tick();
    drive(1, 1, 0, 32'h5, 21'h0, PASS, 4'h8, 32'h6, 21'h0, PASS, 4'hB);
    @(negedge clk); step(); tick();
    #2;
    check("pre_reset_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("async_rst_rsp_data",  64'(bus.rsp_data),  64'(0));
    sb_q.delete();
    m_full = 1'b0;
    m_last = 1'b1;
    drive_idle(1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    drive(1, 1, 1, 32'h9, 21'h0, PASS, 4'h1, 32'hA, 21'h0, PASS, 4'h2);
    @(negedge clk);
    check("post_reset_req0_first", 64'(bus.req0_ready), 64'(1));
    step(); tick();
    drive_idle(1'b1);
    @(negedge clk); step(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
